// File: rtl/spi_master_with_cs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | spi_master_with_cs: SPI master, one active-low CS, 1..MAX_BYTES_PER_CS      |
// | bytes per frame, MSB first. Revision 1.0                                    |
// +-----------------------------------------------------------------------------+
module spi_master_with_cs #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1,
  localparam int CW = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] i_MOSI_Count,
  input  logic [7:0]    i_MOSI_Byte,
  input  logic          i_MOSI_DV,
  output logic          o_MOSI_Ready,
  output logic [CW-1:0] o_MISO_Count,
  output logic          o_MISO_DV,
  output logic [7:0]    o_MISO_Byte,
  output logic          SCK,
  input  logic          MISO,
  output logic          MOSI,
  output logic          CS_L
);

  localparam logic CPOL = 1'((SPI_MODE / 2) % 2);
  localparam logic CPHA = 1'(SPI_MODE % 2);
  localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int INACT_LAST = (CS_INACTIVE_CLKS > 1) ? CS_INACTIVE_CLKS - 1 : 0;
  localparam int IW = (INACT_LAST > 0) ? $clog2(INACT_LAST + 1) : 1;
  localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_BYTES_PER_CS);
  localparam logic [HW-1:0] HALF_LAST  = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [IW-1:0] INACT_DONE = IW'(INACT_LAST);
  // edges_left value (before decrement) on the edge carrying the 8th MISO sample
  localparam logic [4:0]    LAST_SAMPLE = CPHA ? 5'd1 : 5'd2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TRANSFER    = 2'd1,
    CS_INACTIVE = 2'd2
  } state_t;

  state_t        state;
  logic          engine_busy;
  logic [4:0]    edges_left;
  logic [HW-1:0] half_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          dv_pending;
  logic [CW-1:0] remaining;
  logic [IW-1:0] inact_cnt;

  logic          start;
  logic          sample_edge;
  logic [CW-1:0] count_eff;

  always_comb begin
    start = i_MOSI_DV & o_MOSI_Ready;
    // odd-numbered (leading) edges see an even edges_left before the decrement
    sample_edge = ~edges_left[0] ^ CPHA;
    if (i_MOSI_Count == '0)
      count_eff = CW'(1);
    else if (i_MOSI_Count > MAX_CNT)
      count_eff = MAX_CNT;
    else
      count_eff = i_MOSI_Count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      CS_L         <= 1'b1;
      SCK          <= CPOL;
      MOSI         <= 1'b0;
      o_MOSI_Ready <= 1'b0;
      o_MISO_DV    <= 1'b0;
      o_MISO_Byte  <= 8'h00;
      o_MISO_Count <= '0;
      engine_busy  <= 1'b0;
      edges_left   <= 5'd0;
      half_cnt     <= '0;
      tx_sr        <= 8'h00;
      rx_sr        <= 8'h00;
      dv_pending   <= 1'b0;
      remaining    <= '0;
      inact_cnt    <= '0;
    end else begin
      o_MISO_DV <= 1'b0;

      if (start) begin
        engine_busy <= 1'b1;
        edges_left  <= 5'd16;
        half_cnt    <= '0;
        if (CPHA) begin
          tx_sr <= i_MOSI_Byte;
        end else begin
          MOSI  <= i_MOSI_Byte[7];
          tx_sr <= {i_MOSI_Byte[6:0], 1'b0};
        end
      end else if (engine_busy) begin
        if (edges_left == 5'd0) begin
          engine_busy <= 1'b0;
        end else if (half_cnt == HALF_LAST) begin
          half_cnt   <= '0;
          SCK        <= ~SCK;
          edges_left <= edges_left - 5'd1;
          if (sample_edge) begin
            rx_sr <= {rx_sr[6:0], MISO};
            if (edges_left == LAST_SAMPLE)
              dv_pending <= 1'b1;
          end else if (edges_left != 5'd1) begin
            // the final CPHA=0 trailing edge has no bit left to present
            MOSI  <= tx_sr[7];
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end else begin
          half_cnt <= half_cnt + HW'(1);
        end
      end

      if (dv_pending) begin
        dv_pending  <= 1'b0;
        o_MISO_DV   <= 1'b1;
        o_MISO_Byte <= rx_sr;
      end

      if (CS_L)
        o_MISO_Count <= '0;
      else if (o_MISO_DV)
        o_MISO_Count <= o_MISO_Count + CW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            remaining    <= count_eff - CW'(1);
            CS_L         <= 1'b0;
            o_MOSI_Ready <= 1'b0;
            state        <= TRANSFER;
          end else begin
            o_MOSI_Ready <= 1'b1;
          end
        end
        TRANSFER: begin
          if (start) begin
            remaining    <= remaining - CW'(1);
            o_MOSI_Ready <= 1'b0;
          end else if (!engine_busy && remaining == '0) begin
            CS_L         <= 1'b1;
            o_MOSI_Ready <= 1'b0;
            inact_cnt    <= '0;
            state        <= CS_INACTIVE;
          end else begin
            o_MOSI_Ready <= !engine_busy && (remaining != '0);
          end
        end
        CS_INACTIVE: begin
          if (inact_cnt == INACT_DONE) begin
            o_MOSI_Ready <= 1'b1;
            state        <= IDLE;
          end else begin
            inact_cnt <= inact_cnt + IW'(1);
          end
        end
        default: begin
          CS_L         <= 1'b1;
          o_MOSI_Ready <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_with_cs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_spi_master_with_cs: loopback bench over four mode/timing configurations. |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_spi_master_with_cs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] dv;
  logic [7:0] tx_byte [4];
  logic [1:0] tx_cnt  [4];
  wire  [3:0] ready, miso_dv, sck, mosi, cs_l;
  wire  [7:0] rx_byte [4];
  wire  [1:0] rx_cnt  [4];

  // instance g runs SPI mode g; instance 3 also uses a slow SCK and long CS gap
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master_with_cs #(
      .SPI_MODE(g),
      .CLKS_PER_HALF_BIT(g == 3 ? 4 : 2),
      .MAX_BYTES_PER_CS(2),
      .CS_INACTIVE_CLKS(g == 3 ? 10 : 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .i_MOSI_Count(tx_cnt[g]), .i_MOSI_Byte(tx_byte[g]), .i_MOSI_DV(dv[g]),
      .o_MOSI_Ready(ready[g]), .o_MISO_Count(rx_cnt[g]), .o_MISO_DV(miso_dv[g]),
      .o_MISO_Byte(rx_byte[g]), .SCK(sck[g]), .MISO(mosi[g]), .MOSI(mosi[g]),
      .CS_L(cs_l[g])
    );
  end

  int compared   = 0;
  int mismatched = 0;

  function automatic logic cpol(input int i);
    return (i >= 2);
  endfunction
  function automatic int half(input int i);
    return (i == 3) ? 4 : 2;
  endfunction

  typedef struct { int idx; logic [7:0] b; logic [1:0] c; } rx_t;
  rx_t rxq[$];
  int  cyc = 0;
  int  cs_rise [4] = '{default: 0};
  int  idle_bad[4] = '{default: 0};
  int  dv_long [4] = '{default: 0};
  int  hi_run  [4] = '{default: 0};
  int  last_hi [4] = '{default: 0};
  int  rises   [4] = '{default: 0};
  int  gap_bad [4] = '{default: 0};
  int  last_rs [4] = '{default: -1};
  logic [3:0] p_cs, p_sck, p_dv;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      p_dv = 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (miso_dv[i]) begin
          rxq.push_back('{i, rx_byte[i], rx_cnt[i]});
          if (p_dv[i]) dv_long[i]++;
        end
        if (cs_l[i] != p_cs[i] && sck[i] != cpol(i)) idle_bad[i]++;
        if (cs_l[i] && !p_cs[i]) cs_rise[i]++;
        if (cs_l[i]) hi_run[i]++;
        else begin
          if (hi_run[i] > 0) last_hi[i] = hi_run[i];
          hi_run[i] = 0;
        end
        if (cs_l[i]) last_rs[i] = -1;
        else if (sck[i] && !p_sck[i]) begin
          rises[i]++;
          if (last_rs[i] >= 0 && (cyc - last_rs[i]) != 2 * half(i)) gap_bad[i]++;
          last_rs[i] = cyc;
        end
      end
      p_dv = miso_dv;
    end
    p_cs  = cs_l;
    p_sck = sck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string what, input int i);
    compared++;
    mismatched++;
    $display("FAIL timeout waiting for %s on instance %0d", what, i);
  endtask

  task automatic wait_ready(input int i, output bit ok);
    int n = 0;
    while (!ready[i] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = ready[i];
    if (!ok) timeout("o_MOSI_Ready", i);
  endtask

  task automatic pulse(input int i, input logic [1:0] c, input logic [7:0] b);
    dv[i]      = 1'b1;
    tx_byte[i] = b;
    tx_cnt[i]  = c;
    @(negedge clk);
    dv[i]      = 1'b0;
  endtask

  task automatic wait_cs_high(input int i);
    int n = 0;
    while (!cs_l[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cs_l[i]) timeout("CS_L high", i);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input int i, input int n,
                          input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] e;
    chk($sformatf("%s rx_count", tag), rxq.size(), n);
    for (int k = 0; k < n && k < rxq.size(); k++) begin
      e = (k == 0) ? e0 : e1;
      chk($sformatf("%s byte%0d", tag, k), rxq[k].b, e);
      chk($sformatf("%s miso_count%0d", tag, k), rxq[k].c, k);
      chk($sformatf("%s inst%0d", tag, k), rxq[k].idx, i);
    end
  endtask

  typedef struct {
    int         idx;
    logic [1:0] cnt;
    int         n;
    logic [7:0] b0, b1;
    int         exp_n;
    logic [7:0] e0, e1;
    int         min_hi;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v);
    bit ok;
    int r0, ib0, dl0, ri0, gb0;
    r0 = cs_rise[v.idx]; ib0 = idle_bad[v.idx]; dl0 = dv_long[v.idx];
    ri0 = rises[v.idx];  gb0 = gap_bad[v.idx];
    rxq.delete();
    for (int k = 0; k < v.n; k++) begin
      wait_ready(v.idx, ok);
      if (!ok) break;
      pulse(v.idx, v.cnt, (k == 0) ? v.b0 : v.b1);
    end
    wait_cs_high(v.idx);
    check_rx(tag, v.idx, v.exp_n, v.e0, v.e1);
    chk({tag, " cs_rises"}, cs_rise[v.idx] - r0, 1);
    chk({tag, " sck_idle_at_cs_edge"}, idle_bad[v.idx] - ib0, 0);
    chk({tag, " dv_width"}, dv_long[v.idx] - dl0, 0);
    chk({tag, " sck_rises"}, rises[v.idx] - ri0, 8 * v.exp_n);
    if (v.exp_n == 1) chk({tag, " sck_period"}, gap_bad[v.idx] - gb0, 0);
    chk({tag, " cs_high_gap_ok"}, 32'(last_hi[v.idx] >= v.min_hi), 1);
  endtask

  vec_t vecs[9];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit ok;
    int r0, bad;
    rst = 1'b1;
    dv  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tx_byte[i] = 8'h00;
      tx_cnt[i]  = 2'd0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset cs_l%0d", i), cs_l[i], 1);
      chk($sformatf("reset sck%0d", i), sck[i], cpol(i));
      chk($sformatf("reset mosi%0d", i), mosi[i], 0);
      chk($sformatf("reset ready%0d", i), ready[i], 0);
      chk($sformatf("reset miso_dv%0d", i), miso_dv[i], 0);
      chk($sformatf("reset miso_byte%0d", i), rx_byte[i], 0);
      chk($sformatf("reset miso_count%0d", i), rx_cnt[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("ready_after_reset%0d", i), ready[i], 1);

    //            idx cnt   n  b0     b1     exp e0     e1     min_hi
    vecs[0] = '{3, 2'd2, 2, 8'h37, 8'h38, 2, 8'h37, 8'h38, 1};
    vecs[1] = '{3, 2'd1, 1, 8'h5C, 8'h00, 1, 8'h5C, 8'h00, 10};
    vecs[2] = '{0, 2'd1, 1, 8'hA5, 8'h00, 1, 8'hA5, 8'h00, 1};
    vecs[3] = '{1, 2'd1, 1, 8'h5A, 8'h00, 1, 8'h5A, 8'h00, 1};
    vecs[4] = '{2, 2'd1, 1, 8'h5A, 8'h00, 1, 8'h5A, 8'h00, 1};
    vecs[5] = '{0, 2'd0, 1, 8'h3C, 8'h00, 1, 8'h3C, 8'h00, 1};
    vecs[6] = '{0, 2'd3, 2, 8'hC1, 8'h7E, 2, 8'hC1, 8'h7E, 1};
    vecs[7] = '{1, 2'd2, 2, 8'h00, 8'hFF, 2, 8'h00, 8'hFF, 1};
    vecs[8] = '{2, 2'd2, 2, 8'h81, 8'h42, 2, 8'h81, 8'h42, 1};
    for (int v = 0; v < 9; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

    // a DV while the engine is mid-byte must not start or count a byte
    rxq.delete();
    r0 = cs_rise[0];
    wait_ready(0, ok);
    pulse(0, 2'd2, 8'h11);
    repeat (3) @(negedge clk);
    chk("ignored_dv ready_low", ready[0], 0);
    pulse(0, 2'd2, 8'hEE);
    wait_ready(0, ok);
    pulse(0, 2'd2, 8'h22);
    wait_cs_high(0);
    check_rx("ignored_dv", 0, 2, 8'h11, 8'h22);
    chk("ignored_dv cs_rises", cs_rise[0] - r0, 1);

    // long client stall between bytes keeps CS_L low and Ready high
    rxq.delete();
    r0 = cs_rise[0];
    wait_ready(0, ok);
    pulse(0, 2'd2, 8'h69);
    wait_ready(0, ok);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!ready[0] || cs_l[0]) bad++;
    end
    chk("stall ready_and_cs", bad, 0);
    pulse(0, 2'd2, 8'h96);
    wait_cs_high(0);
    check_rx("stall", 0, 2, 8'h69, 8'h96);
    chk("stall cs_rises", cs_rise[0] - r0, 1);

    // asynchronous reset in the middle of a byte, with SCK high
    wait_ready(0, ok);
    rxq.delete();
    pulse(0, 2'd1, 8'hC3);
    repeat (6) @(negedge clk);
    chk("pre_rst cs_low", cs_l[0], 0);
    rst = 1'b1;
    #1;
    chk("mid_rst cs_l", cs_l[0], 1);
    chk("mid_rst sck", sck[0], 0);
    chk("mid_rst miso_dv", miso_dv[0], 0);
    chk("mid_rst ready", ready[0], 0);
    chk("mid_rst miso_byte", rx_byte[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst no_partial_dv", rxq.size(), 0);
    run_vec("post_rst", '{0, 2'd1, 1, 8'h3C, 8'h00, 1, 8'h3C, 8'h00, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
